// File: rtl/square_seq_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state encoding
// and a constant ceil-log2 helper for sizing counters.
package square_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StIter = 2'b10,
    StDone = 2'b11
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/square_seq_if.sv
// Request/result handshake of the sequential squarer.
interface square_seq_if #(
  parameter int unsigned N = 8
);
  logic           start;
  logic [N/2-1:0] a;
  logic [N-1:0]   o;
  logic           ready;
  logic           busy;

  modport master (output start, output a, input o, input ready, input busy);
  modport slave  (input start, input a, output o, output ready, output busy);
endinterface

// File: rtl/square_step_unit.sv
// One radix-2 shift-add step: conditionally accumulate the multiplicand,
// then advance multiplicand and multiplier by one bit.
module square_step_unit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]   acc_i,
  input  logic [N-1:0]   mcand_i,
  input  logic [N/2-1:0] mplier_i,
  output logic [N-1:0]   acc_o,
  output logic [N-1:0]   mcand_o,
  output logic [N/2-1:0] mplier_o
);
  logic [N-1:0] sum;

  always_comb begin
    // Carry-out dropped: the square of an N/2-bit value always fits in N bits.
    sum      = acc_i + mcand_i;
    acc_o    = mplier_i[0] ? sum : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end
endmodule

// File: rtl/square_seq.sv
// Sequential squarer: O = A*A, one multiplier bit per cycle, with a
// start/ready handshake shared with the sequential square-root block.
module square_seq
  import square_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic          clk,
  input logic          rst,
  square_seq_if.slave  bus
);
  localparam int unsigned M = N / 2;
  localparam int unsigned L = clog2(M);

  state_e         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [M-1:0]   mplier_q, mplier_d;
  logic [L-1:0]   count_q, count_d;
  logic [N-1:0]   o_q, o_d;
  logic           ready_q, ready_d;

  logic [N-1:0]   acc_step, mcand_step;
  logic [M-1:0]   mplier_step;

  square_step_unit #(.N(N)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_step),
    .mcand_o  (mcand_step),
    .mplier_o (mplier_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      o_q      <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      o_q      <= o_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    o_d      = o_q;
    ready_d  = ready_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        // A is captured here, not when start is sampled.
        ready_d  = 1'b0;
        mplier_d = bus.a;
        mcand_d  = {{M{1'b0}}, bus.a};
        acc_d    = '0;
        count_d  = '0;
        state_d  = StIter;
      end
      StIter: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        count_d  = count_q + L'(1);
        if (count_q == L'(M - 1)) state_d = StDone;
      end
      StDone: begin
        o_d     = acc_q;
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.o     = o_q;
  assign bus.ready = ready_q;
  assign bus.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_square_seq.sv
// Directed bench for square_seq: N=8 instance for handshake/timing corners,
// N=32 instance for wide-operand boundary values.
module tb_square_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  square_seq_if #(.N(8))  bus_n ();
  square_seq_if #(.N(32)) bus_w ();

  square_seq #(.N(8))  u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));
  square_seq #(.N(32)) u_dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] exp_o;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_wide(input logic [15:0] a, input logic [31:0] exp_o);
    int cycles;
    bus_w.a     = a;
    bus_w.start = 1'b1;
    tick();
    bus_w.start = 1'b0;
    tick();
    cycles = 2;
    check("w_ready_drop", {63'd0, bus_w.ready}, 64'd0);
    while (!bus_w.ready && cycles < 40) begin
      tick();
      cycles++;
    end
    check("w_latency", 64'(cycles), 64'd19);
    check("w_o", {32'd0, bus_w.o}, {32'd0, exp_o});
  endtask

  initial begin
    vecs[0]  = '{4'd0,  8'd0};   vecs[1]  = '{4'd1,  8'd1};
    vecs[2]  = '{4'd2,  8'd4};   vecs[3]  = '{4'd3,  8'd9};
    vecs[4]  = '{4'd4,  8'd16};  vecs[5]  = '{4'd5,  8'd25};
    vecs[6]  = '{4'd6,  8'd36};  vecs[7]  = '{4'd7,  8'd49};
    vecs[8]  = '{4'd8,  8'd64};  vecs[9]  = '{4'd9,  8'd81};
    vecs[10] = '{4'd10, 8'd100}; vecs[11] = '{4'd11, 8'd121};
    vecs[12] = '{4'd12, 8'd144}; vecs[13] = '{4'd13, 8'd169};
    vecs[14] = '{4'd14, 8'd196}; vecs[15] = '{4'd15, 8'd225};

    rst         = 1'b1;
    bus_n.start = 1'b0;
    bus_n.a     = '0;
    bus_w.start = 1'b0;
    bus_w.a     = '0;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_o", {56'd0, bus_n.o}, 64'd0);
      check("idle_ready_busy", {62'd0, bus_n.ready, bus_n.busy}, 64'd0);
    end

    // A=15 single pulse, edge-accurate timing
    bus_n.a     = 4'd15;
    bus_n.start = 1'b1;
    tick();                                    // edge 1
    bus_n.start = 1'b0;
    check("e1_busy", {63'd0, bus_n.busy}, 64'd1);
    tick();                                    // edge 2
    check("e2_busy", {63'd0, bus_n.busy}, 64'd1);
    for (int e = 3; e <= 6; e++) begin
      tick();
      check("iter_ready", {63'd0, bus_n.ready}, 64'd0);
      check("iter_o_hold", {56'd0, bus_n.o}, 64'd0);
    end
    tick();                                    // edge 7
    check("a15_o", {56'd0, bus_n.o}, 64'd225);
    check("a15_ready", {63'd0, bus_n.ready}, 64'd1);
    check("a15_idle", {63'd0, bus_n.busy}, 64'd0);

    // Back-to-back sweep with start held high
    bus_n.start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_n.a = vecs[i].a;
      for (int e = 1; e <= 6; e++) tick();
      check("sweep_ready_low", {63'd0, bus_n.ready}, 64'd0);
      tick();
      check("sweep_o", {56'd0, bus_n.o}, {56'd0, vecs[i].exp_o});
      check("sweep_ready", {63'd0, bus_n.ready}, 64'd1);
    end
    bus_n.start = 1'b0;
    tick();
    check("sweep_stop", {63'd0, bus_n.busy}, 64'd0);

    // A changes after LOAD and a stray start mid-run must not matter
    bus_n.a     = 4'd10;
    bus_n.start = 1'b1;
    tick();                                    // edge 1
    bus_n.start = 1'b0;
    tick();                                    // edge 2 (LOAD)
    bus_n.a = 4'd3;
    tick();                                    // edge 3
    bus_n.start = 1'b1;
    tick();                                    // edge 4
    bus_n.start = 1'b0;
    for (int e = 5; e <= 7; e++) tick();
    check("a10_o", {56'd0, bus_n.o}, 64'd100);
    check("a10_ready", {63'd0, bus_n.ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stray_start_ignored", {63'd0, bus_n.busy}, 64'd0);
    end
    check("a10_o_hold", {56'd0, bus_n.o}, 64'd100);

    // Reset in the middle of an A=12 request
    bus_n.a     = 4'd12;
    bus_n.start = 1'b1;
    tick();
    bus_n.start = 1'b0;
    tick();
    tick();
    @(posedge clk);                            // edge 4
    rst = 1'b1;
    #1;
    check("rst_o", {56'd0, bus_n.o}, 64'd0);
    check("rst_ready_busy", {62'd0, bus_n.ready, bus_n.busy}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", {62'd0, bus_n.ready, bus_n.busy}, 64'd0);
    bus_n.start = 1'b1;
    tick();
    bus_n.start = 1'b0;
    for (int e = 2; e <= 7; e++) tick();
    check("a12_o", {56'd0, bus_n.o}, 64'd144);
    check("a12_ready", {63'd0, bus_n.ready}, 64'd1);

    // Wide operand boundaries
    run_wide(16'd65535, 32'd4294836225);
    run_wide(16'd256, 32'd65536);
    run_wide(16'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
